ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter for the single data port of a synchronous RAM.
// Ownership FSM IDLE/OWN0/OWN1 with a per-ownership burst limit. RAM address, data
// and write-enable come combinationally from the owning port.
// Read data returns one cycle after acceptance as a single-cycle rvalid pulse.
//
// Optional feature (macro ARB_ROUND_ROBIN_EN):
//   defined   - contention goes to the port not served last (last-served pointer).
//   undefined - port 0 wins contention; port 1 yields after each access while req0 waits.
//
// Ports:
//   clock, reset                      clock and asynchronous active-low reset
//   req0/1, wEn0/1, addr0/1, wdata0/1 requester access requests
//   gnt0/1                            port owns the RAM data port this cycle
//   rvalid0/1, rdata0/1               read return pulse and data (data held between pulses)
//   ram_wEn, ram_address,
//   ram_write_data, ram_read_data     RAM data port (read data valid one cycle after address)
module ram_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wEn0,
  input  logic                  wEn1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_wEn,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        burst_cnt;
  logic [CNT_W-1:0]        burst_inc;
  logic                    burst_hit;
  logic                    last_served;
  logic                    acc0;
  logic                    acc1;
  logic                    idle_pick1;
  logic                    yield1;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   rdata0_q;
  logic [DATA_WIDTH-1:0]   rdata1_q;

  assign gnt0 = (state == OWN0);
  assign gnt1 = (state == OWN1);
  assign acc0 = gnt0 & req0;
  assign acc1 = gnt1 & req1;

  // Burst limit is hit when the access accepted this cycle is the BURST_LEN-th one.
  always_comb begin
    burst_inc  = burst_cnt + CNT_W'(1);
    burst_hit  = (burst_inc == CNT_W'(BURST_LEN));
    // Round-robin: contention from IDLE goes to the port not served last.
    idle_pick1 = RR_EN & ~last_served;
    // Fixed priority: port 1 gives way after every access when port 0 waits.
    yield1     = RR_EN ? burst_hit : 1'b1;
  end

  // Ownership FSM with burst counter and last-served pointer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      burst_cnt   <= '0;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && req1) begin
            state       <= idle_pick1 ? OWN1 : OWN0;
            last_served <= idle_pick1;
            burst_cnt   <= '0;
          end else if (req0) begin
            state       <= OWN0;
            last_served <= 1'b0;
            burst_cnt   <= '0;
          end else if (req1) begin
            state       <= OWN1;
            last_served <= 1'b1;
            burst_cnt   <= '0;
          end
        end
        OWN0: begin
          if (!req0) begin
            burst_cnt <= '0;
            if (req1) begin
              state       <= OWN1;
              last_served <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (burst_hit && req1) begin
            state       <= OWN1;
            last_served <= 1'b1;
            burst_cnt   <= '0;
          end else if (burst_hit) begin
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_inc;
          end
        end
        OWN1: begin
          if (!req1) begin
            burst_cnt <= '0;
            if (req0) begin
              state       <= OWN0;
              last_served <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else if (yield1 && req0) begin
            state       <= OWN0;
            last_served <= 1'b0;
            burst_cnt   <= '0;
          end else if (burst_hit) begin
            burst_cnt <= '0;
          end else begin
            burst_cnt <= burst_inc;
          end
        end
        default: begin
          state     <= IDLE;
          burst_cnt <= '0;
        end
      endcase
    end
  end

  // RAM port mux: owner drives during an accepted access, otherwise last values hold.
  always_comb begin
    ram_wEn        = (acc0 & wEn0) | (acc1 & wEn1);
    ram_address    = addr_q;
    ram_write_data = wdata_q;
    if (acc0) begin
      ram_address    = addr0;
      ram_write_data = wdata0;
    end else if (acc1) begin
      ram_address    = addr1;
      ram_write_data = wdata1;
    end
  end

  // Remember last driven RAM address/data for the hold behaviour.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (acc0) begin
      addr_q  <= addr0;
      wdata_q <= wdata0;
    end else if (acc1) begin
      addr_q  <= addr1;
      wdata_q <= wdata1;
    end
  end

  // Read return: pulse the cycle after acceptance, when the RAM output is valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid0 <= acc0 & ~wEn0;
      rvalid1 <= acc1 & ~wEn1;
      if (rvalid0) rdata0_q <= ram_read_data;
      if (rvalid1) rdata1_q <= ram_read_data;
    end
  end

  // Read data passes through during the pulse and is held afterwards.
  assign rdata0 = rvalid0 ? ram_read_data : rdata0_q;
  assign rdata1 = rvalid1 ? ram_read_data : rdata1_q;

endmodule
